// File: rtl/row_feeder.sv
// Row-buffer write feeder: frames the camera pixel stream into per-pixel write strobes,
// zero-extended FIFO data and a running row sum for the integral row chain.
//
// state      | meaning
// IDLE       | waiting for a pixel qualified by i_sof; other pixels are dropped
// STREAM     | accepting pixels of the current frame
// ROW_GAP    | one blocked cycle after the last column of a row; row advances
// FRAME_DONE | one blocked cycle after the last pixel of a frame; counters clear
module row_feeder #(
   parameter int DATA_WIDTH_8        = 8,
   parameter int DATA_WIDTH_16       = 16,
   parameter int FRAME_CAMERA_WIDTH  = 10,
   parameter int FRAME_CAMERA_HEIGHT = 10,
   parameter int COUNT_WIDTH         = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_sof,
   input  logic                     i_valid,
   input  logic [DATA_WIDTH_8-1:0]  i_pixel,
   input  logic                     i_stall,
   output logic                     o_ready,
   output logic                     o_wen,
   output logic [DATA_WIDTH_16-1:0] o_fifo_in,
   output logic [DATA_WIDTH_16-1:0] o_reduction_sum,
   output logic [COUNT_WIDTH-1:0]   o_col,
   output logic [COUNT_WIDTH-1:0]   o_row,
   output logic                     o_end_of_row,
   output logic                     o_end_of_frame
);

   typedef enum logic [1:0] {IDLE, STREAM, ROW_GAP, FRAME_DONE} state_t;

   localparam logic [COUNT_WIDTH-1:0] LAST_COL = COUNT_WIDTH'(FRAME_CAMERA_WIDTH - 1);
   localparam logic [COUNT_WIDTH-1:0] LAST_ROW = COUNT_WIDTH'(FRAME_CAMERA_HEIGHT - 1);

   state_t                   state, state_nxt;
   logic [COUNT_WIDTH-1:0]   col, row, col_nxt, row_nxt, pix_col, pix_row;
   logic                     accept, take, restart, last_col, last_row;
   logic [DATA_WIDTH_16-1:0] pix_ext, sum_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      o_ready   = reset && (state == IDLE || state == STREAM) && !i_stall;
      accept    = i_valid && o_ready;
      // sof on the final pixel of a frame is ignored so the frame completes
      restart   = accept && i_sof && (state == IDLE || !(col == LAST_COL && row == LAST_ROW));
      take      = restart || (accept && state == STREAM);
      pix_col   = restart ? '0 : col;
      pix_row   = restart ? '0 : row;
      last_col  = (pix_col == LAST_COL);
      last_row  = (pix_row == LAST_ROW);
      pix_ext   = DATA_WIDTH_16'(i_pixel);
      sum_nxt   = (pix_col == '0) ? pix_ext : o_reduction_sum + pix_ext;

      case (state)
         IDLE, STREAM: begin
            if (take) begin
               row_nxt = pix_row;
               if (last_col) begin
                  col_nxt   = pix_col;
                  state_nxt = last_row ? FRAME_DONE : ROW_GAP;
               end else begin
                  col_nxt   = pix_col + 1'b1;
                  state_nxt = STREAM;
               end
            end
         end
         ROW_GAP: begin
            col_nxt   = '0;
            row_nxt   = row + 1'b1;
            state_nxt = STREAM;
         end
         FRAME_DONE: begin
            col_nxt   = '0;
            row_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // o_reduction_sum doubles as the row accumulator; it holds while o_wen is low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_wen           <= 1'b0;
         o_end_of_row    <= 1'b0;
         o_end_of_frame  <= 1'b0;
         o_fifo_in       <= '0;
         o_reduction_sum <= '0;
         o_col           <= '0;
         o_row           <= '0;
      end else begin
         o_wen          <= take;
         o_end_of_row   <= take && last_col;
         o_end_of_frame <= take && last_col && last_row;
         if (take) begin
            o_fifo_in       <= pix_ext;
            o_reduction_sum <= sum_nxt;
            o_col           <= pix_col;
            o_row           <= pix_row;
         end
      end
   end

endmodule

// File: doc/row_feeder.md
Name: row_feeder

Overview:
- Transmitter side of the row-buffer write interface: turns the camera pixel stream into the per-pixel write strobe, FIFO data and reduction-sum words that the integral row chain consumes.
- Keeps column and row counters, computes the running horizontal (row) cumulative sum, and frames the stream with end-of-row and end-of-frame markers.
- Sits between the camera capture front end and the first row of the integral buffer chain.

Parameters:
- DATA_WIDTH_8, 8, input pixel width.
- DATA_WIDTH_16, 16, output data and row-sum width.
- FRAME_CAMERA_WIDTH, 10, pixels per row.
- FRAME_CAMERA_HEIGHT, 10, rows per frame.
- COUNT_WIDTH, 12, width of the column and row counters (must hold FRAME_CAMERA_WIDTH-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_sof  input  1  start of frame, qualified by i_valid; marks the first pixel of a frame.
- i_valid  input  1  i_pixel is valid.
- i_pixel  input  DATA_WIDTH_8  camera pixel.
- i_stall  input  1  downstream backpressure; no pixel is accepted while high.
- o_ready  output  1  feeder can accept a pixel this cycle.
- o_wen  output  1  one-cycle write strobe to the row chain.
- o_fifo_in  output  DATA_WIDTH_16  zero-extended pixel.
- o_reduction_sum  output  DATA_WIDTH_16  running row sum including the current pixel.
- o_col  output  COUNT_WIDTH  column of the pixel presented with o_wen.
- o_row  output  COUNT_WIDTH  row of the pixel presented with o_wen.
- o_end_of_row  output  1  high with o_wen for the last column.
- o_end_of_frame  output  1  high with o_wen for the last pixel of the last row.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; all counters and the row sum are 0; o_wen, o_end_of_row, o_end_of_frame and all data outputs are 0; o_ready=0 while reset is asserted.
- Accept condition: i_valid & o_ready. o_ready = (state is IDLE or STREAM) & !i_stall.
- FSM states:
  - IDLE: discard pixels without i_sof. On accept with i_sof, the pixel is col 0 / row 0; go to STREAM.
  - STREAM: accept pixels. On accepting col==FRAME_CAMERA_WIDTH-1:
    - if row < FRAME_CAMERA_HEIGHT-1, go to ROW_GAP;
    - if it is also the last row, go to FRAME_DONE.
  - ROW_GAP: exactly 1 cycle with o_ready=0 (slot for downstream row turnover); col cleared, row incremented; then STREAM.
  - FRAME_DONE: 1 cycle with o_ready=0; counters cleared; then IDLE.
- Output latency is 1 cycle. On the clock after an accept:
  - o_wen=1 and o_fifo_in={8'b0,pixel};
  - o_reduction_sum = pixel when col==0, otherwise previous sum + pixel;
  - o_col and o_row are the coordinates of that pixel.
  - o_wen is 0 in every cycle without a preceding accept. Data outputs hold their last value when o_wen=0.
- Arithmetic: row sum is modulo 2^16 (wraps with no saturation and no flag); integral differencing downstream tolerates the wrap.
- o_end_of_row asserts only with o_wen for col==FRAME_CAMERA_WIDTH-1. o_end_of_frame additionally requires row==FRAME_CAMERA_HEIGHT-1, so both pulse together on the final pixel.
- i_sof accepted in STREAM (mid-frame resync): abandon the current frame. The pixel becomes col 0 / row 0 and the row sum restarts at that pixel. No end markers are emitted for the aborted frame. State stays STREAM.
- i_sof on the last pixel's accept is ignored; the frame completes normally.
- i_stall raised mid-row: o_ready drops in the same cycle, counters and sum freeze, and the in-flight o_wen still completes. Resume continues with no loss or duplication.
- Reset deasserted mid-frame: restarts in IDLE and waits for the next i_sof.

Test Plan:
- W=4, H=2. i_sof with pixels 1,2,3,4 then 5,6,7,8:
  - o_reduction_sum = 1,3,6,10 and 5,11,18,26;
  - o_end_of_row on 10 and 26; o_end_of_frame on 26 only;
  - o_ready low for 1 cycle after pixel 4; back in IDLE after the frame.
- IDLE, pixels 9,9 without i_sof: no o_wen. Then i_sof+3: o_wen with sum 3, col 0, row 0.
- W=300, all pixels 255: sum 65535 at col 256, 254 at col 257 (wrap), no error signalling.
- W=4: pixels 1,2, i_stall high for 3 cycles with i_valid held at 3, then release:
  - o_ready=0 during the stall;
  - sums 1,3,6 with col 2 on 6; exactly 3 o_wen pulses total.
- Mid-row (col 2, row 1), i_sof with pixel 7: o_wen with sum 7, col 0, row 0; no o_end_of_row or o_end_of_frame from the aborted frame.
- Reset low at col 2: all outputs 0 immediately (asynchronous). After release, pixels without i_sof are ignored.
